// File: rtl/dkong_i2s_tx.sv
`timescale 1ns/1ps
// dkong_i2s_tx: I2S transmitter for the soundboard's mixed mono output.
// Buffers 16-bit samples in a small FIFO, then sends each one as a standard
// I2S stereo frame with the same word on left and right. BCLK and LRCLK are
// derived from the single 24.576 MHz system clock.
module dkong_i2s_tx #(
  parameter int BCLK_DIV   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_BITS = 64
) (
  input  logic                          W_CLK_24576M,
  input  logic                          W_RESETn,
  input  logic [15:0]                   I_SAMPLE,
  input  logic                          I_SAMPLE_VALID,
  input  logic                          I_MUTE,
  output logic                          O_BCLK,
  output logic                          O_LRCLK,
  output logic                          O_SDATA,
  output logic [$clog2(FIFO_DEPTH):0]   O_FIFO_LEVEL,
  output logic                          O_UNDERRUN,
  output logic                          O_OVERFLOW
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(FRAME_BITS / 2);
  localparam logic [BIT_W-2:0] SLOT_LSB = (BIT_W-1)'(16);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // Clock generation state
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;

  // Registered serial outputs and shifter
  logic             r_bclk;
  logic             r_lrclk;
  logic             r_sdata;
  logic [15:0]      r_shift;
  logic [15:0]      r_word;
  logic [15:0]      r_held;

  // FIFO state
  logic [15:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;

  // Status pulses
  logic             r_underrun;
  logic             r_overflow;

  // Combinational helpers
  logic             w_bit_tick;
  logic             w_load;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic [BIT_W-2:0] w_slot;
  logic [15:0]      w_next_held;
  logic [15:0]      w_frame_word;

  // Every "div==0" clock is the BCLK falling edge; the frame load is the first of a frame.
  assign w_bit_tick   = (r_div == '0);
  assign w_load       = w_bit_tick && (r_bit == '0);
  assign w_slot       = r_bit[BIT_W-2:0];
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == LVL_FULL);
  assign w_pop        = w_load && !w_empty;
  assign w_push_ok    = I_SAMPLE_VALID && (!w_full || w_pop);
  assign w_drop       = I_SAMPLE_VALID && w_full && !w_pop;
  assign w_next_held  = w_pop ? r_mem[r_rd_ptr] : r_held;
  assign w_frame_word = I_MUTE ? 16'h0000 : w_next_held;

  // Divider and frame bit counter: bit counter advances when the divider wraps.
  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      r_div <= '0;
      r_bit <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_bit <= (r_bit == BIT_LAST) ? '0 : r_bit + BIT_W'(1);
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // BCLK/LRCLK/SDATA generation; LRCLK and data only move on the BCLK falling edge.
  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_sdata <= 1'b0;
      r_shift <= '0;
    end else begin
      r_bclk <= (r_div >= DIV_HALF);
      if (w_bit_tick) begin
        r_lrclk <= (r_bit >= BIT_HALF);
        if (w_slot == '0) begin
          r_sdata <= 1'b0;
          r_shift <= w_load ? w_frame_word : r_word;
        end else if (w_slot <= SLOT_LSB) begin
          r_sdata <= r_shift[15];
          r_shift <= {r_shift[14:0], 1'b0};
        end else begin
          r_sdata <= 1'b0;
        end
      end
    end
  end

  // Frame word capture: the held sample survives underruns, the sent word honours mute.
  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      r_held <= '0;
      r_word <= '0;
    end else if (w_load) begin
      r_held <= w_next_held;
      r_word <= w_frame_word;
    end
  end

  // FIFO pointers and occupancy; a pop from an empty FIFO is ignored.
  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: data only, occupancy tracking makes a reset unnecessary.
  always_ff @(posedge W_CLK_24576M) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= I_SAMPLE;
    end
  end

  // One-cycle status pulses for empty frame starts and dropped pushes.
  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_underrun <= w_load && w_empty;
      r_overflow <= w_drop;
    end
  end

  assign O_BCLK       = r_bclk;
  assign O_LRCLK      = r_lrclk;
  assign O_SDATA      = r_sdata;
  assign O_FIFO_LEVEL = r_count;
  assign O_UNDERRUN   = r_underrun;
  assign O_OVERFLOW   = r_overflow;

endmodule

// File: tb/tb_dkong_i2s_tx.sv
`timescale 1ns/1ps
// tb_dkong_i2s_tx: directed bench for the I2S transmitter.
// Frame words and underrun flags are chosen by hand per frame; every clock
// the expected BCLK/LRCLK/SDATA pattern is derived from the frame offset.
module tb_dkong_i2s_tx;

  localparam int FRAME_CLKS = 512;

  logic        clk         = 1'b0;
  logic        resetN      = 1'b0;
  logic [15:0] sample      = '0;
  logic        sampleValid = 1'b0;
  logic        mute        = 1'b0;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic [2:0]  fifoLevel;
  logic        underrun;
  logic        overflow;

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          cyc         = 0;
  logic [15:0] curWord     = '0;
  logic [15:0] nextWord    = '0;
  logic        curUnder    = 1'b0;
  logic        nextUnder   = 1'b0;

  dkong_i2s_tx dut (
    .W_CLK_24576M   (clk),
    .W_RESETn       (resetN),
    .I_SAMPLE       (sample),
    .I_SAMPLE_VALID (sampleValid),
    .I_MUTE         (mute),
    .O_BCLK         (bclk),
    .O_LRCLK        (lrclk),
    .O_SDATA        (sdata),
    .O_FIFO_LEVEL   (fifoLevel),
    .O_UNDERRUN     (underrun),
    .O_OVERFLOW     (overflow)
  );

  // System clock, 10 ns period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
    end
  endtask

  // Advance one clock and check the serial outputs against the frame position.
  task automatic stepCheck(input logic expOvf);
    int   o;
    int   b;
    int   slot;
    logic expSd;
    @(posedge clk);
    o = cyc % FRAME_CLKS;
    cyc++;
    if (o == 0) begin
      curWord  = nextWord;
      curUnder = nextUnder;
    end
    b     = o / 8;
    slot  = b % 32;
    expSd = (slot >= 1 && slot <= 16) ? curWord[16 - slot] : 1'b0;
    @(negedge clk);
    checkOutput("bclk", bclk, (o % 8) >= 4);
    checkOutput("lrclk", lrclk, b >= 32);
    checkOutput("sdata", sdata, expSd);
    checkOutput("underrun", underrun, (o == 0) ? curUnder : 1'b0);
    checkOutput("overflow", overflow, expOvf);
  endtask

  // Run a number of checked clocks with no push in flight.
  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      stepCheck(1'b0);
    end
  endtask

  // Push one sample for a single clock and check the resulting level.
  task automatic applyStimulus(input logic [15:0] value, input int expLevel, input logic expOvf);
    sample      = value;
    sampleValid = 1'b1;
    stepCheck(expOvf);
    sampleValid = 1'b0;
    checkOutput("level_push", fifoLevel, expLevel);
  endtask

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 1 ms");
    $fatal(1, "[TB] timeout");
  end

  // Directed test sequence.
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_bclk", bclk, 0);
    checkOutput("rst_lrclk", lrclk, 0);
    checkOutput("rst_sdata", sdata, 0);
    checkOutput("rst_level", fifoLevel, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_overflow", overflow, 0);
    resetN = 1'b1;
    cyc    = 0;

    // Two idle frames: silence, underrun at every frame start.
    nextWord  = 16'h0000;
    nextUnder = 1'b1;
    runCycles(2 * FRAME_CLKS);

    // Frame at 1024 is empty; push 8001 just after it for the next frame.
    runCycles(1);
    applyStimulus(16'h8001, 1, 1'b0);
    nextWord  = 16'h8001;
    nextUnder = 1'b0;
    runCycles(1536 - 1026);
    runCycles(1);
    checkOutput("level_after_8001_load", fifoLevel, 0);
    runCycles(FRAME_CLKS - 1);

    // Empty again: the held 8001 is resent with an underrun pulse.
    nextWord  = 16'h8001;
    nextUnder = 1'b1;
    runCycles(1);

    // Five back-to-back pushes: the fifth is dropped.
    applyStimulus(16'h1234, 1, 1'b0);
    applyStimulus(16'hA5C3, 2, 1'b0);
    applyStimulus(16'h0F0F, 3, 1'b0);
    applyStimulus(16'h8000, 4, 1'b0);
    applyStimulus(16'h5555, 4, 1'b1);
    runCycles(2560 - 2054);

    // Push on the frame-load clock while full: both succeed.
    nextWord  = 16'h1234;
    nextUnder = 1'b0;
    applyStimulus(16'h7FFF, 4, 1'b0);
    runCycles(FRAME_CLKS - 1);

    nextWord = 16'hA5C3;
    runCycles(1);
    checkOutput("level_pop_a5c3", fifoLevel, 3);
    runCycles(FRAME_CLKS - 1);

    nextWord = 16'h0F0F;
    runCycles(1);
    checkOutput("level_pop_0f0f", fifoLevel, 2);
    runCycles(FRAME_CLKS - 1);

    nextWord = 16'h8000;
    runCycles(1);
    checkOutput("level_pop_8000", fifoLevel, 1);
    runCycles(FRAME_CLKS - 1);

    // Mute at the load of 7FFF: silent frame, sample still consumed.
    mute     = 1'b1;
    nextWord = 16'h0000;
    runCycles(1);
    mute = 1'b0;
    checkOutput("level_mute_pop", fifoLevel, 0);
    applyStimulus(16'h00C3, 1, 1'b0);
    runCycles(5120 - 4610);

    nextWord = 16'h00C3;
    runCycles(1);
    checkOutput("level_pop_00c3", fifoLevel, 0);
    runCycles(10);
    applyStimulus(16'hBEEF, 1, 1'b0);
    runCycles(5200 - 5132);

    // Reset asserted just after the b=10 edge, where SDATA carries 00C3 bit 6.
    @(posedge clk);
    #1;
    checkOutput("pre_reset_sdata", sdata, 1);
    checkOutput("pre_reset_level", fifoLevel, 1);
    #1 resetN = 1'b0;
    #1;
    checkOutput("mid_rst_bclk", bclk, 0);
    checkOutput("mid_rst_lrclk", lrclk, 0);
    checkOutput("mid_rst_sdata", sdata, 0);
    checkOutput("mid_rst_level", fifoLevel, 0);
    checkOutput("mid_rst_underrun", underrun, 0);
    checkOutput("mid_rst_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    checkOutput("held_rst_sdata", sdata, 0);
    checkOutput("held_rst_level", fifoLevel, 0);

    // Release: new frame from b=0 with an empty FIFO and a cleared held sample.
    resetN    = 1'b1;
    cyc       = 0;
    nextWord  = 16'h0000;
    nextUnder = 1'b1;
    runCycles(1);
    checkOutput("post_rst_level", fifoLevel, 0);
    runCycles(FRAME_CLKS - 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dkong_i2s_tx.md
Name: dkong_i2s_tx

Overview:
- Consumer end of the soundboard's mixed-audio output.
- Accepts 16-bit signed samples, qualified by the soundboard's 48 kHz sample strobe, into a small FIFO.
- Serialises each sample as a standard I2S stereo frame (mono duplicated to L/R) toward the KR260 audio codec.
- Generates BCLK and LRCLK from the 24.576 MHz system clock; no second clock domain.

Parameters:
- BCLK_DIV, 8: system clocks per BCLK period; even, ≥4. Default gives 3.072 MHz = 64·fs.
- FIFO_DEPTH, 4: sample FIFO entries; power of two.
- FRAME_BITS, 64: BCLK periods per LRCLK frame, 32 per channel.

Ports:
- W_CLK_24576M  in  1  system clock, 24.576 MHz.
- W_RESETn  in  1  reset, asynchronous assert, active-low.
- I_SAMPLE  in  16  signed sample, two's complement.
- I_SAMPLE_VALID  in  1  one-cycle push strobe.
- I_MUTE  in  1  when high, transmitted samples are forced to 0.
- O_BCLK  out  1  I2S bit clock.
- O_LRCLK  out  1  word select; 0 = left, 1 = right.
- O_SDATA  out  1  serial data, MSB first.
- O_FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- O_UNDERRUN  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- O_OVERFLOW  out  1  one-cycle pulse when a push is dropped.

Behaviour:
- Reset (async, W_RESETn=0):
  - All outputs 0; FIFO empty; held sample 0.
  - div counter and bit counter 0; shift register 0.
  - After release, the first frame starts on the first clock.
- Clock generation:
  - div counter runs 0..BCLK_DIV-1 and wraps.
  - O_BCLK = 0 for div < BCLK_DIV/2, else 1 (registered).
  - bit counter b runs 0..FRAME_BITS-1 and increments when div wraps.
  - O_LRCLK = 1 when b ≥ FRAME_BITS/2 (registered). It changes on the BCLK falling edge, i.e. the div==0 clock.
- Frame load: occurs on the clock with div==0 and b==0.
  - FIFO non-empty: pop head into held sample.
  - FIFO empty: keep previous held sample and pulse O_UNDERRUN.
  - If I_MUTE is high at this clock, the frame word is 0; the pop still happens.
- Serial data:
  - O_SDATA changes only on div==0 clocks and is stable for the whole BCLK period, so the codec samples it on the rising edge.
  - I2S one-bit delay applies. Per channel half, slot n = b mod 32:
    - n=0: SDATA=0
    - n=1..16: SDATA = word[16-n]
    - n=17..31: SDATA=0
  - Left and right carry the same word.
- Latency: a sample pushed into an empty FIFO appears on the next frame load. Its MSB is on SDATA at b=1, 8 clocks after the load.
- FIFO:
  - Push on I_SAMPLE_VALID. If full and no pop in the same cycle, the sample is dropped and O_OVERFLOW pulses.
  - Simultaneous push and pop when full: both succeed; level unchanged.
  - Simultaneous push and pop when empty: the pop sees empty (underrun, previous sample reused); the push is stored; level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH. Level is updated in the same cycle as push/pop.
- Rates: at 48 kHz push and 48 kHz frame rate, steady-state level stays at 1 ± 1; no overflow or underrun once primed.
- Reset mid-frame: all state clears immediately, outputs go to 0, and no partial frame is resumed.

Test Plan:
- Reset, then no pushes for 2 frames → O_BCLK period 8 clocks; O_LRCLK period 512 clocks; SDATA constantly 0; O_UNDERRUN pulses at clock 0 and clock 512.
- Push 16'h8001 one cycle after reset → frame 2 left slots 1..16 = 1,0×14,1; right slots identical; slot 0 and 17..31 = 0; FIFO_LEVEL returns to 0 at the load.
- Push 5 samples back-to-back while no frame load occurs → level 4; fifth push pulses O_OVERFLOW; subsequent frames transmit samples 1..4 in order.
- With FIFO full, push and frame load on the same clock → no overflow; level stays 4.
- I_MUTE=1 with FIFO holding 16'h7FFF → SDATA all 0 for that frame; level decremented by 1.
- Assert W_RESETn low at b=10 mid-frame → all outputs 0 within the same clock; after release, the frame restarts at b=0 with an empty FIFO.
